// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the long-latency hazard scoreboard.
package hazard_scoreboard_pkg;
  // Register-index width for the 32-entry DeltaRV register file
  localparam int RIDX_W_DEF = 5;
  // Bit positions inside id_valid_reg (bit 0 marks rd and is not used here)
  localparam int VR_RS1 = 1;
  localparam int VR_RS2 = 2;
endpackage

// File: rtl/pend_counter.sv
// Per-register count of in-flight long-latency writes.
module pend_counter #(
  parameter int CNT_W   = 3,
  parameter int MAX_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nz,
  output logic             is_last
);
  // Up/down count; a simultaneous inc and dec leaves the count unchanged
  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else if (inc && !dec && count != CNT_W'(MAX_CNT))
      count <= count + 1'b1;
    else if (dec && !inc && count != '0)
      count <= count - 1'b1;
  end

  // Status flags used for hazard forwarding and completion qualification
  always_comb begin
    nz      = (count != '0);
    is_last = (count == CNT_W'(1));
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard of outstanding long-latency writes; stalls ID on
// a read of an in-flight register or when the outstanding limit would be hit.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_COUNT      = 32,
  parameter int RIDX_W         = RIDX_W_DEF,
  parameter int MAX_PENDING    = 4,
  parameter int CNT_W          = 3,
  parameter bit FWD_STORE_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [RIDX_W-1:0] iss_rd,
  input  logic              cmp_valid,
  input  logic [RIDX_W-1:0] cmp_rd,
  input  logic [RIDX_W-1:0] id_rs1,
  input  logic [RIDX_W-1:0] id_rs2,
  input  logic [2:0]        id_valid_reg,
  input  logic              id_mem_write,
  input  logic              id_long_op,
  input  logic              flush,
  output logic              stall,
  output logic              full,
  output logic [CNT_W-1:0]  outstanding,
  output logic              err_underflow
);
  logic [REG_COUNT-1:0][CNT_W-1:0] pend;
  logic [REG_COUNT-1:0]            pend_nz, pend_last, busy;
  logic [CNT_W-1:0]                tot, tot_next;
  logic iss, iss_cnt, cmp, cmp_bad, hit1, hit2, full_next;
  logic unused_vr0;

  assign unused_vr0 = id_valid_reg[0];

  // Qualify issue/completion; an issue at the limit without a completion is
  // dropped from the counts but still counts as a same-cycle hazard
  always_comb begin
    iss      = iss_valid && !flush && (iss_rd != '0);
    cmp      = cmp_valid && (cmp_rd != '0) && pend_nz[cmp_rd];
    cmp_bad  = cmp_valid && (cmp_rd != '0) && !pend_nz[cmp_rd];
    iss_cnt  = iss && ((tot != CNT_W'(MAX_PENDING)) || cmp);
    tot_next = tot;
    if (iss_cnt && !cmp)      tot_next = tot + 1'b1;
    else if (cmp && !iss_cnt) tot_next = tot - 1'b1;
  end

  // x0 never has a write in flight
  assign pend[0]      = '0;
  assign pend_nz[0]   = 1'b0;
  assign pend_last[0] = 1'b0;
  assign busy[0]      = 1'b0;

  for (genvar r = 1; r < REG_COUNT; r++) begin : g_reg
    logic hit_iss, hit_cmp;
    assign hit_iss = (iss_rd == RIDX_W'(r));
    assign hit_cmp = (cmp_rd == RIDX_W'(r));

    pend_counter #(.CNT_W(CNT_W), .MAX_CNT(MAX_PENDING)) u_pend (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (iss_cnt && hit_iss),
      .dec     (cmp && hit_cmp),
      .count   (pend[r]),
      .nz      (pend_nz[r]),
      .is_last (pend_last[r])
    );

    // Busy unless the last pending write completes now (forwarded)
    assign busy[r] = (pend_nz[r] && !(cmp && hit_cmp && pend_last[r])) ||
                     (iss && hit_iss);
  end

  // Total outstanding counter
  always_ff @(posedge clk) begin
    if (!rst_n) tot <= '0;
    else        tot <= tot_next;
  end

  // Sticky flag for completions that match no pending write
  always_ff @(posedge clk) begin
    if (!rst_n)       err_underflow <= 1'b0;
    else if (cmp_bad) err_underflow <= 1'b1;
  end

  // Hazard detection against the ID-stage sources
  always_comb begin
    hit1      = id_valid_reg[VR_RS1] && (id_rs1 != '0) && busy[id_rs1];
    hit2      = id_valid_reg[VR_RS2] && (id_rs2 != '0) && busy[id_rs2] &&
                !(FWD_STORE_DATA && id_mem_write);
    full_next = (tot_next == CNT_W'(MAX_PENDING));
    stall     = rst_n && (hit1 || hit2 || (id_long_op && full_next));
    full      = (tot == CNT_W'(MAX_PENDING));
    outstanding = tot;
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed scenarios then random traffic against an
// array-based reference model; a second instance has store forwarding off.
module tb_hazard_scoreboard;
  localparam int MAXP = 4;

  logic clk = 1'b0;
  logic rst_n, iss_valid, cmp_valid, id_mem_write, id_long_op, flush;
  logic [4:0] iss_rd, cmp_rd, id_rs1, id_rs2;
  logic [2:0] id_valid_reg;
  logic stall_f, full_f, err_f, stall_n, full_n, err_n;
  logic [2:0] out_f, out_n;

  int errors = 0, checks = 0;
  int pend_m[32];
  int tot_m = 0;
  bit err_m = 0, known = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.MAX_PENDING(MAXP), .FWD_STORE_DATA(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .cmp_valid(cmp_valid), .cmp_rd(cmp_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_valid_reg(id_valid_reg), .id_mem_write(id_mem_write),
    .id_long_op(id_long_op), .flush(flush), .stall(stall_f), .full(full_f),
    .outstanding(out_f), .err_underflow(err_f));

  hazard_scoreboard #(.MAX_PENDING(MAXP), .FWD_STORE_DATA(1'b0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .cmp_valid(cmp_valid), .cmp_rd(cmp_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_valid_reg(id_valid_reg), .id_mem_write(id_mem_write),
    .id_long_op(id_long_op), .flush(flush), .stall(stall_n), .full(full_n),
    .outstanding(out_n), .err_underflow(err_n));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Would the write really retire this cycle (nonzero rd, something pending)
  function automatic bit cmp_real();
    return cmp_valid && cmp_rd != 0 && pend_m[cmp_rd] > 0;
  endfunction

  function automatic bit iss_raw();
    return iss_valid && !flush && iss_rd != 0;
  endfunction

  function automatic int tot_after();
    int t = tot_m;
    bit i = iss_raw(), c = cmp_real();
    if (i && tot_m == MAXP && !c) i = 0;
    return t + int'(i) - int'(c);
  endfunction

  function automatic bit reg_busy(int r);
    int left = pend_m[r] - ((cmp_real() && cmp_rd == r) ? 1 : 0);
    return (left > 0) || (iss_raw() && iss_rd == r);
  endfunction

  function automatic bit exp_stall(bit fwd);
    bit h1, h2;
    if (!rst_n) return 0;
    h1 = id_valid_reg[1] && id_rs1 != 0 && reg_busy(id_rs1);
    h2 = id_valid_reg[2] && id_rs2 != 0 && reg_busy(id_rs2) && !(fwd && id_mem_write);
    return h1 || h2 || (id_long_op && tot_after() == MAXP);
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      foreach (pend_m[r]) pend_m[r] = 0;
      tot_m = 0; err_m = 0; known = 1;
    end else begin
      bit i = iss_raw(), c = cmp_real();
      if (cmp_valid && cmp_rd != 0 && pend_m[cmp_rd] == 0) err_m = 1;
      if (i && tot_m == MAXP && !c) i = 0;
      if (i) begin pend_m[iss_rd]++; tot_m++; end
      if (c) begin pend_m[cmp_rd]--; tot_m--; end
    end
  endtask

  task automatic cycle(string tag);
    @(negedge clk);
    chk({tag, ":stall"}, 32'(stall_f), 32'(exp_stall(1)));
    chk({tag, ":stall_nofwd"}, 32'(stall_n), 32'(exp_stall(0)));
    if (known) begin
      chk({tag, ":full"}, 32'(full_f), 32'(tot_m == MAXP));
      chk({tag, ":outstanding"}, 32'(out_f), 32'(tot_m));
      chk({tag, ":err"}, 32'(err_f), 32'(err_m));
      chk({tag, ":out_nofwd"}, 32'(out_n), 32'(tot_m));
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1; iss_valid = 0; iss_rd = 0; cmp_valid = 0; cmp_rd = 0;
    id_rs1 = 0; id_rs2 = 0; id_valid_reg = 0; id_mem_write = 0;
    id_long_op = 0; flush = 0;
  endtask

  task automatic iss(int rd);  iss_valid = 1; iss_rd = 5'(rd); endtask
  task automatic cmp(int rd);  cmp_valid = 1; cmp_rd = 5'(rd); endtask
  task automatic rd1(int rs);  id_rs1 = 5'(rs); id_valid_reg = 3'b010; endtask

  initial begin
    idle(); rst_n = 0; cycle("reset0");
    idle(); rst_n = 0; cycle("reset1");

    // Load-use: stall in issue cycle and next, cleared by forwarded completion
    idle(); iss(5); rd1(5); cycle("lu_issue");
    idle(); rd1(5); cycle("lu_wait");
    idle(); cmp(5); rd1(5); cycle("lu_cmp");
    idle(); rd1(5); cycle("lu_after");

    // Store data forwarding on rs2
    idle(); iss(7); cycle("st_iss");
    idle(); id_rs2 = 7; id_valid_reg = 3'b100; id_mem_write = 1; cycle("st_fwd");
    idle(); cmp(7); cycle("st_cmp");

    // WAW: two writes to x3
    idle(); iss(3); cycle("waw_i1");
    idle(); iss(3); cycle("waw_i2");
    idle(); cmp(3); rd1(3); cycle("waw_c1");
    idle(); rd1(3); cycle("waw_hold");
    idle(); cmp(3); rd1(3); cycle("waw_c2");
    idle(); rd1(3); cycle("waw_done");

    // Full limit, long-op stall, completion relief, saturation
    for (int r = 1; r <= 4; r++) begin idle(); iss(r); cycle("full_fill"); end
    idle(); id_long_op = 1; cycle("full_lo");
    idle(); iss(5); cycle("full_sat");
    idle(); id_long_op = 1; cmp(1); cycle("full_relief");
    idle(); cmp(5); cycle("full_sat_underflow");
    for (int r = 2; r <= 4; r++) begin idle(); cmp(r); cycle("full_drain"); end

    // Simultaneous issue/completion, x0 handling
    idle(); iss(9); cycle("sim_i");
    idle(); iss(9); cmp(9); rd1(9); cycle("sim_both");
    idle(); rd1(9); cycle("sim_hold");
    idle(); cmp(9); cycle("sim_c");
    idle(); iss(0); rd1(0); cycle("x0_iss");
    idle(); cmp(0); cycle("x0_cmp");

    // Underflow and stickiness (after a reset so the flag starts clear)
    idle(); rst_n = 0; cycle("uf_rst");
    idle(); cycle("uf_clear");
    idle(); cmp(6); cycle("uf_set");
    idle(); cycle("uf_sticky");
    idle(); cycle("uf_sticky2");

    // Flush suppresses issue
    idle(); iss(8); flush = 1; rd1(8); cycle("flush");
    idle(); rd1(8); cycle("flush_after");

    // Reset mid-operation with three writes in flight
    for (int r = 1; r <= 3; r++) begin idle(); iss(r); cycle("rst_fill"); end
    idle(); rst_n = 0; rd1(1); id_long_op = 1; cycle("rst_assert");
    idle(); rd1(1); cycle("rst_after");
    idle(); cmp(2); cycle("rst_late_cmp");
    idle(); cycle("rst_late_err");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      rst_n        = ($urandom_range(0, 99) != 0);
      iss_valid    = ($urandom_range(0, 99) < 45);
      iss_rd       = 5'($urandom_range(0, 7));
      cmp_valid    = ($urandom_range(0, 99) < 45);
      cmp_rd       = 5'($urandom_range(0, 7));
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      id_valid_reg = 3'($urandom);
      id_mem_write = 1'($urandom);
      id_long_op   = ($urandom_range(0, 3) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised load/long-latency hazard unit for the DeltaRV pipeline. It replaces the single-cycle load-use stall check with a per-register scoreboard that tracks up to MAX_PENDING outstanding long-latency writes, such as variable-latency loads and multi-cycle mul/div. It sits beside the ID stage. EX reports each issued long-latency op, WB reports each completion, and the block asserts `stall` whenever the instruction in ID reads a register with a write still in flight, or would exceed the outstanding-op limit.

## Interface
Parameters:
- `REG_COUNT`, 32: number of architectural registers; register 0 is hardwired zero.
- `RIDX_W`, 5: register index width, clog2(REG_COUNT).
- `MAX_PENDING`, 4: maximum outstanding long-latency writes, counted across all registers; range 1..15.
- `CNT_W`, 3: counter width, clog2(MAX_PENDING+1).
- `FWD_STORE_DATA`, 1: when 1, a store in ID does not stall on rs2, because store data is forwarded late into MEM.

Ports (clock and reset first):
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `iss_valid`, in, 1: EX issues a long-latency op this cycle.
- `iss_rd`, in, RIDX_W: destination register of the issued op.
- `cmp_valid`, in, 1: a long-latency result is written back this cycle.
- `cmp_rd`, in, RIDX_W: destination register of the completed op.
- `id_rs1`, `id_rs2`, in, RIDX_W: source registers of the instruction in ID.
- `id_valid_reg`, in, 3: bit 1 marks rs1 as used, bit 2 marks rs2 as used; bit 0 (rd) is ignored.
- `id_mem_write`, in, 1: the instruction in ID is a store.
- `id_long_op`, in, 1: the instruction in ID will issue as a long-latency op.
- `flush`, in, 1: pipeline flush; suppresses the `iss_valid` of this cycle.
- `stall`, out, 1: hold IF/ID and inject a bubble into EX.
- `full`, out, 1: outstanding count equals MAX_PENDING.
- `outstanding`, out, CNT_W: total in-flight long-latency writes.
- `err_underflow`, out, 1: sticky flag; set by a completion to a register with no pending write.

## Operation
- State:
  - one CNT_W-bit counter `pend[r]` per register, r = 1..REG_COUNT-1;
  - a total counter `tot`;
  - the sticky error bit.
- Effective issue: `iss = iss_valid && !flush && iss_rd != 0`.
- Effective completion: `cmp = cmp_valid && cmp_rd != 0 && pend[cmp_rd] != 0`.
- A `cmp_valid` to a nonzero register whose `pend` is 0 is ignored and sets `err_underflow`. A completion to x0 is ignored silently.
- Counter updates per register r:
  - issue only: +1;
  - completion only: −1;
  - both in the same cycle: unchanged.
- `tot` follows the same rule, aggregated over all registers.
- An issue while `tot == MAX_PENDING` with no completion in the same cycle is a protocol violation: the counters saturate and `err_underflow` is not set.
- Register r is busy for ID when either condition holds:
  - `pend[r] != 0` and not (`cmp` to r and `pend[r] == 1`). A completion is forwarded, so the last completion clears the hazard in the same cycle.
  - `iss` to r in this cycle. This is the classic load-use case.
- Source hit conditions:
  - `hit1 = id_valid_reg[1] && id_rs1 != 0 && busy(id_rs1)`.
  - `hit2 = id_valid_reg[2] && id_rs2 != 0 && busy(id_rs2) && !(FWD_STORE_DATA && id_mem_write)`.
- `stall = rst_n && (hit1 || hit2 || (id_long_op && full_next))`.
  - `full_next` is true when `tot` plus issue minus completion equals MAX_PENDING.
- WAW: multiple writes pending to the same rd are counted. The register stays busy until every one of them completes.

## Timing
- Reset: all `pend` and `tot` clear to 0; `err_underflow` clears to 0. `stall` is 0 while `rst_n` is low. Reset mid-operation discards all pending state; in-flight completions that arrive after reset set `err_underflow`.
- `stall`, `full` and `outstanding` are combinational from current state and current-cycle inputs, with zero latency. `full` and `outstanding` reflect registered state only.
- Counter state updates one cycle after the issue or completion is presented.
- `flush` affects only the issue in the same cycle. Ops already counted still complete normally.

## Structure
- Shared package entries:
  - register-index width;
  - the `id_valid_reg` bit positions (RS1 = 1, RS2 = 2).
- Sub-module `pend_counter`: one per-register up/down saturating counter with inc, dec and is_last outputs. Generate REG_COUNT-1 instances; register 0 has no instance.

## Test plan
- Load-use: issue rd=5, then in the next cycle ID has rs1=5 with `id_valid_reg=3'b010` → `stall=1` in the issue cycle and the next. With completion to 5 in cycle 3 → `stall=0` in cycle 3.
- Store data forwarding: `pend[7]=1`; ID store with rs2=7, `id_valid_reg=3'b100`, `FWD_STORE_DATA=1` → `stall=0`. The same case with `FWD_STORE_DATA=0` → `stall=1`.
- WAW: two issues to rd=3 in consecutive cycles, then one completion → `pend[3]=1` and ID reading x3 still stalls. After the second completion → no stall, `outstanding=0`.
- Full: MAX_PENDING=4; four issues to x1..x4 → `full=1`. ID with `id_long_op=1` → stall. A completion presented in the same cycle → no stall.
- Simultaneous events and x0: issue and completion to rd=9 in the same cycle with `pend[9]=1` → `pend[9]` stays 1. Issue to x0 → `outstanding` unchanged. Completion to x6 with `pend[6]=0` → `err_underflow=1` and it stays set.
- Flush and reset: `iss_valid` together with `flush` → no count. Reset asserted with `outstanding=3` → 0 on the next edge, `stall=0` during reset.
